// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencer feeding a 2-entry {pc, instr} FIFO toward decode.
// Latency: first instruction valid two edges after reset release or after a redirect edge.
// Backpressure: ready_i low lets the FIFO fill to 2 entries, after which PC and FIFO hold.
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets trap into FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    // Entry 0 is always the head; entry 1 shifts down on a pop.
    logic [31:0] e0_pc_q, e0_pc_d, e0_ins_q, e0_ins_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_ins_q, e1_ins_d;

    logic [31:0] redir_tgt;
    logic        redir_misaligned;
    logic        pop;
    logic        push;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_tgt        = redirect_pc_i;
    assign redir_misaligned = |redirect_pc_i[1:0];
    assign fault_o          = (state_q == FAULT);
`else
    // Without the check, low address bits are simply dropped so FAULT is unreachable.
    assign redir_tgt        = {redirect_pc_i[31:2], 2'b00};
    assign redir_misaligned = 1'b0;
    assign fault_o          = 1'b0;
`endif

    assign imem_addr_o = pc_q;
    assign valid_o     = (count_q != 2'd0);
    assign pc_o        = e0_pc_q;
    assign instr_o     = e0_ins_q;

    // A redirect wins over both pop and push; a pop frees a slot for a same-cycle push.
    assign pop  = valid_o && ready_i && !redirect_i;
    assign push = (state_q == RUN) && !redirect_i && ((count_q != 2'd2) || pop);

    // Next-state: FSM transitions, PC sequencing and FIFO shift/fill.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        e0_pc_d  = e0_pc_q;
        e0_ins_d = e0_ins_q;
        e1_pc_d  = e1_pc_q;
        e1_ins_d = e1_ins_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    count_d = 2'd0;
                    pc_d    = redir_tgt;
                    if (redir_misaligned) begin
                        state_d = FAULT;
                    end
                end else begin
                    if (pop) begin
                        e0_pc_d  = e1_pc_q;
                        e0_ins_d = e1_ins_q;
                        count_d  = count_q - 2'd1;
                    end
                    if (push) begin
                        pc_d = pc_q + 32'd4;
                        if (count_d == 2'd0) begin
                            e0_pc_d  = pc_q;
                            e0_ins_d = imem_instr_i;
                        end else begin
                            e1_pc_d  = pc_q;
                            e1_ins_d = imem_instr_i;
                        end
                        count_d = count_d + 2'd1;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State registers; reset clears everything so outputs read zero while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            e0_pc_q  <= 32'd0;
            e0_ins_q <= 32'd0;
            e1_pc_q  <= 32'd0;
            e1_ins_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            e0_pc_q  <= e0_pc_d;
            e0_ins_q <= e0_ins_d;
            e1_pc_q  <= e1_pc_d;
            e1_ins_q <= e1_ins_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: cycle table for startup/backpressure, scoreboard for redirects and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fault_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0000_001C) return 32'h0021_9093;
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    assign imem_instr_i = rom(imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consume expected PCs; once streaming starts every cycle must deliver the next one.
    task automatic run_sb(input string name, input int n);
        logic [31:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({name, "_valid"}, {31'd0, valid_o}, 32'd1);
            if (valid_o && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({name, "_pc"}, pc_o, e);
                chk({name, "_instr"}, instr_o, rom(e));
            end
        end
        chk({name, "_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    typedef struct {
        bit          do_reset;
        logic        ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Startup with ready high; BOOT-cycle redirect must be ignored.
        vecs[0]  = '{1, 1, 1, 32'h40, 0, 32'h0, 32'h0};
        vecs[1]  = '{0, 1, 0, 32'h0,  0, 32'h0, 32'h0};
        vecs[2]  = '{0, 1, 0, 32'h0,  1, 32'h0, 32'h4};
        vecs[3]  = '{0, 1, 0, 32'h0,  1, 32'h4, 32'h8};
        vecs[4]  = '{0, 1, 0, 32'h0,  1, 32'h8, 32'hC};
        vecs[5]  = '{0, 1, 0, 32'h0,  1, 32'hC, 32'h10};
        // Startup with ready low for five cycles, then drain without gap.
        vecs[6]  = '{1, 0, 0, 32'h0,  0, 32'h0, 32'h0};
        vecs[7]  = '{0, 0, 0, 32'h0,  0, 32'h0, 32'h0};
        vecs[8]  = '{0, 0, 0, 32'h0,  1, 32'h0, 32'h4};
        vecs[9]  = '{0, 0, 0, 32'h0,  1, 32'h0, 32'h8};
        vecs[10] = '{0, 0, 0, 32'h0,  1, 32'h0, 32'h8};
        vecs[11] = '{0, 1, 0, 32'h0,  1, 32'h0, 32'h8};
        vecs[12] = '{0, 1, 0, 32'h0,  1, 32'h4, 32'hC};
        vecs[13] = '{0, 1, 0, 32'h0,  1, 32'h8, 32'h10};
        vecs[14] = '{0, 1, 0, 32'h0,  1, 32'hC, 32'h14};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_reset) begin
                @(negedge clk);
                rst = 1'b1;
                ready_i = 1'b0;
                redirect_i = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                chk("rst_pc", pc_o, 32'h0);
                chk("rst_instr", instr_o, 32'h0);
                chk("rst_fault", {31'd0, fault_o}, 32'd0);
            end else begin
                @(negedge clk);
            end
            ready_i       = vecs[i].ready;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].redir_pc;
            chk($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
                chk($sformatf("vec%0d_instr", i), instr_o, rom(vecs[i].exp_pc));
            end
        end

        // Redirect to 0x1C with two entries buffered and ready high: flush wins over pop.
        @(negedge clk);
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("buf_valid", {31'd0, valid_o}, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_001C;
        ready_i       = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
        chk("redir1c_gap", {31'd0, valid_o}, 32'd0);
        exp_q.push_back(32'h1C);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        run_sb("redir1c", 3);

        // Redirect near the top of the address space: PC wraps to zero.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_i = 1'b0;
        chk("wrap_gap", {31'd0, valid_o}, 32'd0);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        run_sb("wrap", 4);

        // Misaligned redirect target.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0006;
        @(negedge clk);
        redirect_i = 1'b0;
        chk("mis_gap", {31'd0, valid_o}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'd0, fault_o}, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            redirect_i = 1'b0;
            chk("fault_valid", {31'd0, valid_o}, 32'd0);
            chk("fault_hold", {31'd0, fault_o}, 32'd1);
            chk("fault_addr", imem_addr_o, 32'h0000_0006);
        end
`else
        chk("mis_nofault", {31'd0, fault_o}, 32'd0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        run_sb("mis", 2);
        chk("mis_fault_after", {31'd0, fault_o}, 32'd0);
`endif

        // Reset pulse mid-stream with two entries buffered.
        @(negedge clk);
        rst = 1'b1;
        ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        chk("pre_rst_addr", imem_addr_o, 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        chk("arst_pc", pc_o, 32'h0);
        chk("arst_instr", instr_o, 32'h0);
        chk("arst_fault", {31'd0, fault_o}, 32'd0);
        chk("arst_addr", imem_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        chk("restart_boot", {31'd0, valid_o}, 32'd0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        run_sb("restart", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
